// File: rtl/ucode_pkg.sv
// Shared definitions for the microcoded multicycle RISC-V controller:
// microinstruction addresses, sequencing codes, opcodes and control-word layout.
package ucode_pkg;

    localparam int ADDR_W = 4;
    localparam int SEQ_W  = 3;

    // Microinstruction addresses
    localparam logic [ADDR_W-1:0] S_FETCH  = 4'd0;
    localparam logic [ADDR_W-1:0] S_DECODE = 4'd1;
    localparam logic [ADDR_W-1:0] S_MEMADR = 4'd2;
    localparam logic [ADDR_W-1:0] S_MEMRD  = 4'd3;
    localparam logic [ADDR_W-1:0] S_MEMWB  = 4'd4;
    localparam logic [ADDR_W-1:0] S_MEMWR  = 4'd5;
    localparam logic [ADDR_W-1:0] S_EXECR  = 4'd6;
    localparam logic [ADDR_W-1:0] S_ALUWB  = 4'd7;
    localparam logic [ADDR_W-1:0] S_EXECI  = 4'd8;
    localparam logic [ADDR_W-1:0] S_JAL    = 4'd9;
    localparam logic [ADDR_W-1:0] S_BEQ    = 4'd10;

    // Highest valid microinstruction; sequencing past it is an error
    localparam logic [ADDR_W-1:0] LAST_STATE = S_BEQ;

    // Sequencing field codes; 101..111 are reserved
    typedef enum logic [SEQ_W-1:0] {
        SEQ_NEXT = 3'b000,
        SEQ_DSP1 = 3'b001,
        SEQ_DSP2 = 3'b010,
        SEQ_FTCH = 3'b011,
        SEQ_ALWB = 3'b100
    } seq_e;

    // Instruction opcodes (instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Control-word field positions: sequencing field sits in the low bits
    localparam int CW_SEQ_LSB = 0;
    localparam int CW_SEQ_MSB = CW_SEQ_LSB + SEQ_W - 1;

endpackage

// File: rtl/ucode_dispatch.sv
// Combinational next-address logic: (seq, opcode, upc) -> (next_upc, bad).
// Every error path steers back to Fetch so the sequencer never runs into
// unprogrammed ROM words.
module ucode_dispatch
    import ucode_pkg::*;
(
    input  logic [SEQ_W-1:0]  i_seq,
    input  logic [6:0]        i_opcode,
    input  logic [ADDR_W-1:0] i_upc,
    output logic [ADDR_W-1:0] o_next_upc,
    output logic              o_bad
);

    // Decode the sequencing field; opcode only matters for the dispatch codes
    always_comb begin
        o_next_upc = S_FETCH;
        o_bad      = 1'b0;
        case (i_seq)
            SEQ_NEXT: begin
                // Compare before incrementing so the last state cannot wrap forward
                if (i_upc == LAST_STATE) begin
                    o_bad = 1'b1;
                end else begin
                    o_next_upc = i_upc + ADDR_W'(1);
                end
            end
            SEQ_DSP1: begin
                case (i_opcode)
                    OP_LW:   o_next_upc = S_MEMADR;
                    OP_SW:   o_next_upc = S_MEMADR;
                    OP_R:    o_next_upc = S_EXECR;
                    OP_I:    o_next_upc = S_EXECI;
                    OP_JAL:  o_next_upc = S_JAL;
                    OP_BEQ:  o_next_upc = S_BEQ;
                    default: o_bad      = 1'b1;
                endcase
            end
            SEQ_DSP2: begin
                case (i_opcode)
                    OP_LW:   o_next_upc = S_MEMRD;
                    OP_SW:   o_next_upc = S_MEMWR;
                    default: o_bad      = 1'b1;
                endcase
            end
            SEQ_FTCH: o_next_upc = S_FETCH;
            SEQ_ALWB: o_next_upc = S_ALUWB;
            default:  o_bad      = 1'b1;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register for the microprogrammed controller. upc addresses the
// combinational microcode ROM, whose sequencing field returns on seq.
// Stall handshake: en=1 means the current microinstruction completes and the
// next address is taken on this edge; en=0 holds upc and suppresses pulses.
module micro_sequencer
    import ucode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SEQ_W-1:0]  seq,
    input  logic [6:0]        opcode,
    output logic [ADDR_W-1:0] upc,
    output logic              branch,
    output logic              instr_done,
    output logic              illegal_op
);

    logic [ADDR_W-1:0] r_upc;
    logic              r_instr_done;
    logic              r_illegal_op;
    logic [ADDR_W-1:0] w_next_upc;
    logic              w_bad;

    ucode_dispatch u_dispatch (
        .i_seq      (seq),
        .i_opcode   (opcode),
        .i_upc      (r_upc),
        .o_next_upc (w_next_upc),
        .o_bad      (w_bad)
    );

    // uPC and status pulses; async reset aborts any instruction back to Fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc        <= S_FETCH;
            r_instr_done <= 1'b0;
            r_illegal_op <= 1'b0;
        end else if (en) begin
            r_upc        <= w_next_upc;
            r_instr_done <= (w_next_upc == S_FETCH) && !w_bad;
            r_illegal_op <= w_bad;
        end else begin
            r_instr_done <= 1'b0;
            r_illegal_op <= 1'b0;
        end
    end

    // Branch qualifier: PC update in the BEQ state is gated by Zero downstream
    always_comb begin
        branch = (r_upc == S_BEQ);
    end

    assign upc        = r_upc;
    assign instr_done = r_instr_done;
    assign illegal_op = r_illegal_op;

endmodule
